// File: rtl/sprite_plot_engine.sv
// Sprite plot engine: scans a SPRITE_W x SPRITE_H block of pixels to a VGA adapter for draw/erase requests.
// Define SPRITE_PLOT_CLIP_EN to suppress off-screen pixels; otherwise off-screen coordinates wrap.
module sprite_plot_engine #(
   parameter int unsigned SPRITE_W = 4,
   parameter int unsigned SPRITE_H = 4,
   parameter logic [2:0]  BG_COLOR = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [8:0] x,
   input  logic [7:0] y,
   input  logic [2:0] color,
   input  logic       sd,
   input  logic       se,
   output logic       dd,
   output logic       de,
   output logic [8:0] plot_x,
   output logic [7:0] plot_y,
   output logic [2:0] plot_color,
   output logic       plot,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] DX_LAST = 4'(SPRITE_W - 1);
   localparam logic [3:0] DY_LAST = 4'(SPRITE_H - 1);

   state_t     state, state_n;
   logic [8:0] x_l, x_l_n;
   logic [7:0] y_l, y_l_n;
   logic [2:0] col_l, col_l_n;
   logic       erase, erase_n;
   logic [3:0] dx, dx_n, dy, dy_n;
   logic       dd_n, de_n, plot_n, busy_n;
   logic [8:0] px_n;
   logic [7:0] py_n;
   logic [2:0] pc_n;
   logic       pixel, req;
   logic [9:0] sum_x;
   logic [8:0] sum_y;

   // Pixel outputs are computed from the next-state counters so that, during RUN,
   // the registered plot_x/plot_y always correspond to the current dx/dy.
   always_comb begin
      state_n = state;
      x_l_n   = x_l;
      y_l_n   = y_l;
      col_l_n = col_l;
      erase_n = erase;
      dx_n    = dx;
      dy_n    = dy;
      dd_n    = 1'b0;
      de_n    = 1'b0;
      pixel   = 1'b0;
      req     = erase ? se : sd;
      case (state)
         IDLE: begin
            if (se || sd) begin
               state_n = RUN;
               x_l_n   = x;
               y_l_n   = y;
               erase_n = se;
               col_l_n = se ? BG_COLOR : color;
               dx_n    = '0;
               dy_n    = '0;
               pixel   = 1'b1;
            end
         end
         RUN: begin
            if (dx == DX_LAST && dy == DY_LAST) begin
               state_n = DONE;
               dd_n    = !erase && req;
               de_n    = erase && req;
            end else begin
               pixel = 1'b1;
               if (dx == DX_LAST) begin
                  dx_n = '0;
                  dy_n = dy + 4'd1;
               end else begin
                  dx_n = dx + 4'd1;
               end
            end
         end
         DONE: begin
            if (req) begin
               dd_n = !erase;
               de_n = erase;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      sum_x  = {1'b0, x_l_n} + {6'b0, dx_n};
      sum_y  = {1'b0, y_l_n} + {5'b0, dy_n};
      px_n   = plot_x;
      py_n   = plot_y;
      pc_n   = plot_color;
      plot_n = 1'b0;
      if (pixel) begin
`ifdef SPRITE_PLOT_CLIP_EN
         px_n   = sum_x[8:0];
         py_n   = sum_y[7:0];
         plot_n = (sum_x <= 10'd319) && (sum_y <= 9'd239);
`else
         px_n   = (sum_x > 10'd319) ? 9'(sum_x - 10'd320) : sum_x[8:0];
         py_n   = (sum_y > 9'd239) ? 8'(sum_y - 9'd240) : sum_y[7:0];
         plot_n = 1'b1;
`endif
         pc_n = col_l_n;
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         x_l        <= '0;
         y_l        <= '0;
         col_l      <= '0;
         erase      <= 1'b0;
         dx         <= '0;
         dy         <= '0;
         dd         <= 1'b0;
         de         <= 1'b0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         plot_x     <= '0;
         plot_y     <= '0;
         plot_color <= '0;
      end else begin
         state      <= state_n;
         x_l        <= x_l_n;
         y_l        <= y_l_n;
         col_l      <= col_l_n;
         erase      <= erase_n;
         dx         <= dx_n;
         dy         <= dy_n;
         dd         <= dd_n;
         de         <= de_n;
         plot       <= plot_n;
         busy       <= busy_n;
         plot_x     <= px_n;
         plot_y     <= py_n;
         plot_color <= pc_n;
      end
   end

endmodule

// File: tb/tb_sprite_plot_engine.sv
// Directed self-checking bench for sprite_plot_engine (4x4 sprite, default colours).
module tb_sprite_plot_engine;

   logic       clk = 1'b0;
   logic       resetn, sd, se;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] color;
   logic       dd, de, plot, busy;
   logic [8:0] plot_x;
   logic [7:0] plot_y;
   logic [2:0] plot_color;

   int checks = 0;
   int passed = 0;

   logic [8:0] cx [32];
   logic [7:0] cy [32];
   logic [2:0] cc [32];
   logic [8:0] ex [32];
   logic [7:0] ey [32];

   sprite_plot_engine #(
      .SPRITE_W(4),
      .SPRITE_H(4),
      .BG_COLOR(3'b000)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .x(x),
      .y(y),
      .color(color),
      .sd(sd),
      .se(se),
      .dd(dd),
      .de(de),
      .plot_x(plot_x),
      .plot_y(plot_y),
      .plot_color(plot_color),
      .plot(plot),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Records plot pulses until dd/de is seen (bounded); optionally moves x/y/color at cycle mod_at.
   task automatic capture(input int mod_at, output int n, output int cyc, output bit both);
      n = 0;
      cyc = 0;
      both = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (dd && de) both = 1'b1;
         if (plot) begin
            if (n < 32) begin
               cx[n] = plot_x;
               cy[n] = plot_y;
               cc[n] = plot_color;
            end
            n++;
         end
         if (i == mod_at) begin
            x = 9'd100;
            y = 8'd100;
            color = 3'd1;
         end
         if (dd || de) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; sd = 1'b1; se = 1'b0; x = 9'd5; y = 8'd5; color = 3'd7;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (plot !== 1'b0) $display("FAIL reset_plot got %b want 0", plot); else passed++;
      checks++; if ({dd, de} !== 2'b00) $display("FAIL reset_done got %b want 00", {dd, de}); else passed++;
      checks++;
      if ({plot_x, plot_y, plot_color} !== 20'h0)
         $display("FAIL reset_coords got %h want 00000", {plot_x, plot_y, plot_color});
      else passed++;
      resetn = 1'b1; sd = 1'b0;
      @(negedge clk);
      checks++; if ({busy, plot} !== 2'b00) $display("FAIL idle_after_reset got %b want 00", {busy, plot}); else passed++;
   endtask

   task automatic test_draw();
      int n, cyc; bit both;
      x = 9'd10; y = 8'd20; color = 3'b100; sd = 1'b1;
      capture(0, n, cyc, both);
      checks++; if (n !== 16) $display("FAIL draw_count got %0d want 16", n); else passed++;
      checks++; if (cyc !== 17) $display("FAIL draw_latency got %0d want 17", cyc); else passed++;
      checks++; if ({dd, de, plot, busy} !== 4'b1001) $display("FAIL draw_done got %b want 1001", {dd, de, plot, busy}); else passed++;
      checks++; if (both !== 1'b0) $display("FAIL draw_both got %b want 0", both); else passed++;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({cx[i], cy[i], cc[i]} !== {9'(10 + i % 4), 8'(20 + i / 4), 3'b100})
            $display("FAIL draw_px%0d got %h want %h", i, {cx[i], cy[i], cc[i]}, {9'(10 + i % 4), 8'(20 + i / 4), 3'b100});
         else passed++;
      end
      @(negedge clk);
      checks++; if (dd !== 1'b1) $display("FAIL draw_hold got %b want 1", dd); else passed++;
      sd = 1'b0;
      @(negedge clk);
      checks++; if ({dd, busy} !== 2'b00) $display("FAIL draw_release got %b want 00", {dd, busy}); else passed++;
   endtask

   task automatic test_erase();
      int n, cyc; bit both;
      x = 9'd0; y = 8'd0; color = 3'd7; se = 1'b1;
      capture(0, n, cyc, both);
      checks++; if (n !== 16) $display("FAIL erase_count got %0d want 16", n); else passed++;
      checks++; if (cyc !== 17) $display("FAIL erase_latency got %0d want 17", cyc); else passed++;
      checks++; if ({dd, de} !== 2'b01) $display("FAIL erase_done got %b want 01", {dd, de}); else passed++;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({cx[i], cy[i], cc[i]} !== {9'(i % 4), 8'(i / 4), 3'b000})
            $display("FAIL erase_px%0d got %h want %h", i, {cx[i], cy[i], cc[i]}, {9'(i % 4), 8'(i / 4), 3'b000});
         else passed++;
      end
      se = 1'b0;
      @(negedge clk);
      checks++; if ({de, busy} !== 2'b00) $display("FAIL erase_release got %b want 00", {de, busy}); else passed++;
   endtask

   task automatic test_priority();
      int n, cyc; bit both;
      x = 9'd50; y = 8'd60; color = 3'd5; sd = 1'b1; se = 1'b1;
      capture(0, n, cyc, both);
      checks++; if ({dd, de} !== 2'b01) $display("FAIL prio_erase_first got %b want 01", {dd, de}); else passed++;
      checks++; if ({cc[0], cc[15]} !== 6'b000000) $display("FAIL prio_erase_color got %b want 000000", {cc[0], cc[15]}); else passed++;
      checks++; if (both !== 1'b0) $display("FAIL prio_both got %b want 0", both); else passed++;
      se = 1'b0;
      capture(0, n, cyc, both);
      checks++; if (n !== 16) $display("FAIL prio_draw_count got %0d want 16", n); else passed++;
      checks++; if (cyc !== 18) $display("FAIL prio_draw_latency got %0d want 18", cyc); else passed++;
      checks++; if ({dd, de} !== 2'b10) $display("FAIL prio_draw_done got %b want 10", {dd, de}); else passed++;
      checks++;
      if ({cx[15], cy[15], cc[15]} !== {9'd53, 8'd63, 3'd5})
         $display("FAIL prio_draw_last got %h want %h", {cx[15], cy[15], cc[15]}, {9'd53, 8'd63, 3'd5});
      else passed++;
      sd = 1'b0;
      @(negedge clk);
      checks++; if ({dd, busy} !== 2'b00) $display("FAIL prio_release got %b want 00", {dd, busy}); else passed++;
   endtask

   task automatic test_clip();
      int n, cyc, en; bit both;
      en = 0;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
`ifdef SPRITE_PLOT_CLIP_EN
            if (318 + i <= 319 && 238 + j <= 239) begin
               ex[en] = 9'(318 + i);
               ey[en] = 8'(238 + j);
               en++;
            end
`else
            ex[en] = (318 + i > 319) ? 9'(318 + i - 320) : 9'(318 + i);
            ey[en] = (238 + j > 239) ? 8'(238 + j - 240) : 8'(238 + j);
            en++;
`endif
         end
      end
      x = 9'd318; y = 8'd238; color = 3'd2; sd = 1'b1;
      capture(0, n, cyc, both);
      checks++; if (n !== en) $display("FAIL edge_count got %0d want %0d", n, en); else passed++;
      checks++; if (cyc !== 17) $display("FAIL edge_latency got %0d want 17", cyc); else passed++;
      for (int i = 0; i < en; i++) begin
         checks++;
         if ({cx[i], cy[i], cc[i]} !== {ex[i], ey[i], 3'd2})
            $display("FAIL edge_px%0d got %h want %h", i, {cx[i], cy[i], cc[i]}, {ex[i], ey[i], 3'd2});
         else passed++;
      end
      sd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      int n, cyc; bit both;
      x = 9'd10; y = 8'd20; color = 3'd6; sd = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({plot, plot_x, plot_y} !== {1'b1, 9'd10, 8'd21})
         $display("FAIL midrun_5th got %h want %h", {plot, plot_x, plot_y}, {1'b1, 9'd10, 8'd21});
      else passed++;
      resetn = 1'b0;
      @(negedge clk);
      checks++; if ({plot, busy, dd} !== 3'b000) $display("FAIL midrun_abort got %b want 000", {plot, busy, dd}); else passed++;
      @(negedge clk);
      checks++; if ({plot, busy, dd} !== 3'b000) $display("FAIL midrun_held got %b want 000", {plot, busy, dd}); else passed++;
      resetn = 1'b1;
      capture(0, n, cyc, both);
      checks++; if (n !== 16) $display("FAIL midrun_redraw_count got %0d want 16", n); else passed++;
      checks++; if (cyc !== 17) $display("FAIL midrun_redraw_latency got %0d want 17", cyc); else passed++;
      checks++;
      if ({cx[0], cy[0], cc[0], cx[15], cy[15]} !== {9'd10, 8'd20, 3'd6, 9'd13, 8'd23})
         $display("FAIL midrun_redraw_px got %h want %h", {cx[0], cy[0], cc[0], cx[15], cy[15]}, {9'd10, 8'd20, 3'd6, 9'd13, 8'd23});
      else passed++;
      sd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_input_change();
      int n, cyc; bit both;
      x = 9'd30; y = 8'd40; color = 3'd3; sd = 1'b1;
      capture(3, n, cyc, both);
      checks++; if (n !== 16) $display("FAIL latch_count got %0d want 16", n); else passed++;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({cx[i], cy[i], cc[i]} !== {9'(30 + i % 4), 8'(40 + i / 4), 3'd3})
            $display("FAIL latch_px%0d got %h want %h", i, {cx[i], cy[i], cc[i]}, {9'(30 + i % 4), 8'(40 + i / 4), 3'd3});
         else passed++;
      end
      sd = 1'b0;
      @(negedge clk);
      checks++; if ({dd, busy} !== 2'b00) $display("FAIL latch_release got %b want 00", {dd, busy}); else passed++;
   endtask

   initial begin
      test_reset();
      test_draw();
      test_erase();
      test_priority();
      test_clip();
      test_reset_midrun();
      test_input_change();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sprite_plot_engine.md
SPRITE_PLOT_ENGINE -- requirements
Module: sprite_plot_engine

Interface
REQ-001 Parameter SPRITE_W, default 4: sprite width in pixels, 1..16.
REQ-002 Parameter SPRITE_H, default 4: sprite height in pixels, 1..16.
REQ-003 Parameter BG_COLOR, default 3'b000: colour written during erase.
REQ-004 clk  input  1  system clock; the only clock domain.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 x  input  9  sprite top-left column, 0..319.
REQ-007 y  input  8  sprite top-left row, 0..239.
REQ-008 color  input  3  sprite draw colour.
REQ-009 sd  input  1  draw request, level, held by requester until dd seen.
REQ-010 se  input  1  erase request, level, held by requester until de seen.
REQ-011 dd  output  1  draw done.
REQ-012 de  output  1  erase done.
REQ-013 plot_x  output  9  pixel column to VGA adapter.
REQ-014 plot_y  output  8  pixel row to VGA adapter.
REQ-015 plot_color  output  3  pixel colour to VGA adapter.
REQ-016 plot  output  1  pixel write enable, one pixel per cycle when high.
REQ-017 busy  output  1  high in RUN and DONE states.

Function
REQ-018 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE: sd or se high -> RUN next cycle; x, y, operation and colour (color for draw, BG_COLOR for erase) latched on that edge.
REQ-020 sd and se both high in IDLE -> erase accepted; draw stays pending.
REQ-021 x, y, color changes after acceptance have no effect on the operation in progress.
REQ-022 RUN: offset counters dx (0..SPRITE_W-1), dy (0..SPRITE_H-1) scan row-major, dx fastest, one pixel per cycle.
REQ-023 Each RUN cycle: plot_x = x_latched+dx, plot_y = y_latched+dy, plot_color = latched colour, plot high.
REQ-024 Request accepted at edge N -> first plot high for cycle N+1, last for cycle N+SPRITE_W*SPRITE_H, done high from cycle N+SPRITE_W*SPRITE_H+1.
REQ-025 RUN -> DONE after the pixel dx=SPRITE_W-1, dy=SPRITE_H-1; plot low in DONE.
REQ-026 DONE: dd (draw) or de (erase) held high while the accepted request stays high; dd and de never high together.
REQ-027 DONE: accepted request low -> dd/de low and IDLE on the next edge; new request accepted no earlier than the edge after that.
REQ-028 Accepted request dropping during RUN has no effect; the scan completes and DONE exits on the first cycle request is seen low.
REQ-029 Coordinate sums computed 10/9 bits wide before the range check; no silent truncation.
REQ-030 dd, de, plot never high in IDLE.

Reset
REQ-031 resetn low at an edge -> IDLE; dd, de, plot, busy = 0; plot_x, plot_y, plot_color, dx, dy, latched registers = 0.
REQ-032 Reset mid-RUN or mid-DONE aborts at once; no further plot pulse; no done pulse.
REQ-033 resetn low with sd/se high -> no acceptance until the first edge with resetn high.

Configuration
REQ-034 Macro SPRITE_PLOT_CLIP_EN defined: pixels with x_latched+dx>319 or y_latched+dy>239 output plot low for that cycle; scan timing unchanged.
REQ-035 SPRITE_PLOT_CLIP_EN undefined: such pixels wrap (column minus 320, row minus 240) and plot stays high.

Verification
REQ-036 Reset, sd=1, x=10, y=20, color=3'b100 -> 16 plot pulses (10..13, 20..23) row-major, colour 4; dd high at cycle 18 after request; drop sd -> dd low and IDLE next edge.
REQ-037 se=1, x=0, y=0 -> 16 plots colour 3'b000, de high, dd stays 0.
REQ-038 sd=se=1 in IDLE -> erase first (de); after se drops with sd held -> draw runs, dd asserts.
REQ-039 x=318, y=238, draw: CLIP_EN -> 4 plot pulses (318..319 x 238..239); no CLIP_EN -> 16 pulses, columns 0..1 and rows 0..1 wrapped.
REQ-040 resetn low at 5th RUN cycle -> plot low next cycle, dd never asserts, busy 0; sd still high after release -> fresh full 16-pixel draw.
REQ-041 x changed to 100 on 3rd RUN cycle -> all 16 plot_x values still from original x.
